spi_mem_responder: RTL and testbench
====================================

# spi_mem_responder

SPI mode-0 responder (slave) emulating a small 25-series serial EEPROM, clocked by the system clock and oversampling the SPI pins. It is the far end of the SPI master link: it receives commands on SPI_MOSI and returns data on SPI_MISO. It serves as a synthesizable stand-in for the external SPI memory in loop-back and FPGA builds.

## Interface
- ADDR_W, 8: memory address width; depth = 2^ADDR_W bytes.
- PAGE_BYTES, 16: write page size, power of two, ≤ 2^ADDR_W.
- WR_BUSY_CYCLES, 64: CLK_I cycles WIP stays set after a write.

- CLK_I  in  1  system clock; must be ≥ 8× SPI_CLK frequency.
- RST_N_I  in  1  asynchronous, active-low reset.
- SPI_CLK  in  1  serial clock from master, idle low.
- SPI_CS_N  in  1  chip select, active low.
- SPI_MOSI  in  1  serial data from master.
- SPI_WP_N  in  1  write protect, active low; sampled at the WRITE command decode.
- SPI_MISO  out  1  serial data to master.
- SPI_MISO_OE  out  1  MISO drive enable; high only in the read-data and status phases.
- BUSY_O  out  1  mirrors the WIP status bit.

## Operation
- SPI_CLK, SPI_CS_N and SPI_MOSI each pass through a 2-FF synchronizer. The synchronized SPI_CLK drives rise/fall edge detectors.
- MOSI is sampled on each detected SCK rise, MSB first. MISO shifts on each detected SCK fall.
- SPI_CS_N high (synchronized) forces state IDLE at any time and discards any partial byte.
- States:
  - IDLE: waits for CS_N low, then goes to CMD.
  - CMD: collects 8 bits, then decodes the command.
  - ADDR: collects ADDR_W bits. Goes to RD_DATA for READ or WR_DATA for WRITE.
  - RD_DATA: shifts out mem[addr]. Each byte increments addr, wrapping 2^ADDR_W−1 → 0.
  - WR_DATA: writes each completed byte to mem[addr]. addr increments within its page; the low log2(PAGE_BYTES) bits wrap and the upper bits are held.
  - STATUS: shifts out the status byte repeatedly, refreshed at each byte boundary.
  - IGNORE: stays until CS_N high; MISO_OE is low.
- Commands:
  - READ 0x03: goes to ADDR.
  - WRITE 0x02: goes to ADDR only if WEL=1, SPI_WP_N=1 and WIP=0. Otherwise goes to IGNORE.
  - WREN 0x06: sets WEL when CS_N rises, if the byte was complete and WIP=0.
  - WRDI 0x04: clears WEL when CS_N rises.
  - RDSR 0x05: goes to STATUS.
  - Any other code: goes to IGNORE.
- While WIP=1, every command except RDSR goes to IGNORE.
- Status byte = {6'b0, WEL, WIP}.
- When CS_N rises after a WRITE with ≥1 complete data byte:
  - WEL clears.
  - WIP sets and the busy counter loads WR_BUSY_CYCLES−1.
  - WIP clears when the counter reaches 0.
- A WRITE aborted with 0 complete data bytes leaves WEL unchanged and does not set WIP.
- Memory: single-port byte RAM. It is initialized to 0xFF for simulation and is not affected by reset. Reads and writes are on CLK_I.

## Timing
- Reset values:
  - SPI_MISO=0, SPI_MISO_OE=0, BUSY_O=0.
  - WEL=0, WIP=0, busy counter=0, state=IDLE.
  - Synchronizers load the idle values: CS_N=1, SCK=0.
- Edge-detect latency: an SCK edge is acted on 3 CLK_I cycles after the pin edge.
- The RAM read for the next read byte is issued on the 8th SCK rise of the current byte (or of the last address bit). Data is registered in time for the following SCK fall.
- The first read-data bit is driven on the SCK fall after the last address bit. MISO_OE rises on that same fall.
- A write to mem occurs 1 CLK_I cycle after the 8th data-bit rise.
- WIP sets 1 cycle after the synchronized CS_N rise. It stays high for exactly WR_BUSY_CYCLES cycles.
- If CS_N rises in the same cycle as an SCK edge, CS_N wins: the edge is ignored.
- If reset is asserted mid-transaction, the block returns to IDLE immediately. A write byte not yet committed is lost.

## Structure
- Shared package spi_mem_pkg holds:
  - the command opcodes (CMD_READ, CMD_WRITE, CMD_WREN, CMD_WRDI, CMD_RDSR);
  - the state enum;
  - the status bit indices.
- One sub-module, spi_pin_sync: 2-FF synchronizers plus the SCK rise/fall pulse generation.

## Test plan
- WREN, then WRITE addr 0x10 data 0xA5 0x5A; poll RDSR → WIP=1 for 64 cycles, then status 0x00. READ 0x10 → 0xA5 0x5A.
- READ 0xFE for 3 bytes after reset → 0xFF 0xFF 0xFF. Addr wraps to 0x00 without error.
- WREN, then WRITE at 0x1E with 4 bytes 0x01..0x04 → mem[0x1E]=01, [0x1F]=02, [0x10]=03, [0x11]=04 (page wrap).
- WRITE without WREN, or with SPI_WP_N=0 → memory unchanged, MISO_OE stays 0, status 0x00.
- Command 0x06 issued while WIP=1 → WEL stays 0. RDSR during WIP → 0x01.
- CS_N raised after 5 bits of a data byte → byte discarded, WEL unchanged. A RST_N_I pulse mid-READ → MISO=0, OE=0, next transaction decodes normally.

Source files
------------

// File: rtl/spi_mem_responder_pkg.sv
// spi_mem_pkg: shared definitions for the SPI serial-EEPROM responder.
//   - command opcodes of the emulated 25-series memory
//   - FSM state encoding
//   - status register bit positions and a status-byte builder
package spi_mem_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRDI  = 8'h04;
  localparam logic [7:0] CMD_RDSR  = 8'h05;
  localparam logic [7:0] CMD_WREN  = 8'h06;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_CMD     = 3'd1;
  localparam state_t ST_ADDR    = 3'd2;
  localparam state_t ST_RD_DATA = 3'd3;
  localparam state_t ST_WR_DATA = 3'd4;
  localparam state_t ST_STATUS  = 3'd5;
  localparam state_t ST_IGNORE  = 3'd6;

  localparam int SR_WIP = 0;
  localparam int SR_WEL = 1;

  function automatic logic [7:0] status_byte(input logic wel, input logic wip);
    logic [7:0] s;
    s         = '0;
    s[SR_WEL] = wel;
    s[SR_WIP] = wip;
    return s;
  endfunction

endpackage

// File: rtl/spi_mem_responder_if.sv
// spi_mem_if: SPI pin bundle between a master and the memory responder.
//   SPI_CLK / SPI_CS_N / SPI_MOSI / SPI_WP_N : master -> responder
//   SPI_MISO / SPI_MISO_OE / BUSY_O          : responder -> master side
interface spi_mem_if;
  logic SPI_CLK;
  logic SPI_CS_N;
  logic SPI_MOSI;
  logic SPI_WP_N;
  logic SPI_MISO;
  logic SPI_MISO_OE;
  logic BUSY_O;

  modport master (
    output SPI_CLK, SPI_CS_N, SPI_MOSI, SPI_WP_N,
    input  SPI_MISO, SPI_MISO_OE, BUSY_O
  );

  modport slave (
    input  SPI_CLK, SPI_CS_N, SPI_MOSI, SPI_WP_N,
    output SPI_MISO, SPI_MISO_OE, BUSY_O
  );
endinterface

// File: rtl/spi_mem_responder_pin_sync.sv
// spi_pin_sync: brings the asynchronous SPI pins into the system clock domain.
//   i_sck, i_cs_n, i_mosi : raw SPI pins
//   o_cs_n, o_mosi        : 2-FF synchronized chip select and data
//   o_sck_rise/o_sck_fall : one-cycle pulses on synchronized SCK edges
// A pin edge produces a pulse that the consumer acts on at the third
// clk edge after the pin changed. MOSI travels through the same depth as
// SCK so it is aligned with the rise pulse that samples it.
module spi_pin_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sck,
  input  logic i_cs_n,
  input  logic i_mosi,
  output logic o_sck_rise,
  output logic o_sck_fall,
  output logic o_cs_n,
  output logic o_mosi
);

  // Bit [1] of each pair is the synchronized value.
  logic [1:0] r_sck_ff;
  logic [1:0] r_cs_ff;
  logic [1:0] r_mosi_ff;
  logic       r_sck_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_ff   <= 2'b00;
      r_cs_ff    <= 2'b11;
      r_mosi_ff  <= 2'b00;
      r_sck_prev <= 1'b0;
    end else begin
      r_sck_ff   <= {r_sck_ff[0], i_sck};
      r_cs_ff    <= {r_cs_ff[0], i_cs_n};
      r_mosi_ff  <= {r_mosi_ff[0], i_mosi};
      r_sck_prev <= r_sck_ff[1];
    end
  end

  assign o_sck_rise = r_sck_ff[1] & ~r_sck_prev;
  assign o_sck_fall = ~r_sck_ff[1] & r_sck_prev;
  assign o_cs_n     = r_cs_ff[1];
  assign o_mosi     = r_mosi_ff[1];

endmodule

// File: rtl/spi_mem_responder.sv
// spi_mem_responder: SPI mode-0 slave emulating a small 25-series EEPROM.
//   CLK_I   : system clock, at least 8x the SPI clock
//   RST_N_I : asynchronous active-low reset
//   bus     : SPI pins (slave modport) plus BUSY_O, which mirrors WIP
// Supports READ, WRITE (page-wrapped), WREN, WRDI and RDSR. Writes set
// WIP for WR_BUSY_CYCLES cycles after chip select rises.
module spi_mem_responder
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int PAGE_BYTES     = 16,
  parameter int WR_BUSY_CYCLES = 64
) (
  input  logic      CLK_I,
  input  logic      RST_N_I,
  spi_mem_if.slave  bus
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int CNT_W  = (ADDR_W > 8) ? $clog2(ADDR_W) : 3;
  localparam int BUSY_W = (WR_BUSY_CYCLES > 1) ? $clog2(WR_BUSY_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] PG_MASK = ADDR_W'(PAGE_BYTES - 1);

  logic w_sck_rise, w_sck_fall, w_cs_n, w_mosi;

  spi_pin_sync u_pin_sync (
    .clk        (CLK_I),
    .rst_n      (RST_N_I),
    .i_sck      (bus.SPI_CLK),
    .i_cs_n     (bus.SPI_CS_N),
    .i_mosi     (bus.SPI_MOSI),
    .o_sck_rise (w_sck_rise),
    .o_sck_fall (w_sck_fall),
    .o_cs_n     (w_cs_n),
    .o_mosi     (w_mosi)
  );

  state_t             r_state;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [6:0]         r_shift_in;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_is_read;
  logic               r_wren_pend, r_wrdi_pend, r_wr_any;
  logic               r_rd_pend, r_wr_pend;
  logic [7:0]         r_wr_data, r_rd_data;
  logic [2:0]         r_tx_cnt;
  logic [7:0]         r_tx_shift;
  logic               r_miso, r_miso_oe;
  logic               r_wel, r_wip;
  logic [BUSY_W-1:0]  r_busy_cnt;

  logic [7:0]         w_byte;
  logic [7:0]         w_tx_byte;
  logic [ADDR_W-1:0]  w_addr_page_inc;

  assign w_byte    = {r_shift_in, w_mosi};
  assign w_tx_byte = (r_state == ST_STATUS) ? status_byte(r_wel, r_wip) : r_rd_data;
  // Only the in-page offset bits advance; the page number is held.
  assign w_addr_page_inc = (r_addr & ~PG_MASK) | ((r_addr + 1'b1) & PG_MASK);

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift_in  <= '0;
      r_addr      <= '0;
      r_is_read   <= 1'b0;
      r_wren_pend <= 1'b0;
      r_wrdi_pend <= 1'b0;
      r_wr_any    <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_wr_pend   <= 1'b0;
      r_wr_data   <= '0;
      r_tx_cnt    <= '0;
      r_tx_shift  <= '0;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_wel       <= 1'b0;
      r_wip       <= 1'b0;
      r_busy_cnt  <= '0;
    end else begin
      // One-cycle RAM strobes; re-asserted below when a byte completes.
      r_rd_pend <= 1'b0;
      r_wr_pend <= 1'b0;

      // The RAM access strobed last cycle uses r_addr now; step it afterwards.
      if (r_rd_pend) r_addr <= r_addr + 1'b1;
      if (r_wr_pend) r_addr <= w_addr_page_inc;

      if (r_wip) begin
        if (r_busy_cnt == '0) r_wip <= 1'b0;
        else                  r_busy_cnt <= r_busy_cnt - 1'b1;
      end

      if (w_cs_n) begin
        // End of transaction: commit deferred status effects, then idle.
        // Chip select outranks any SCK edge seen in the same cycle.
        if (r_state != ST_IDLE) begin
          if (r_wr_any) begin
            r_wel      <= 1'b0;
            r_wip      <= 1'b1;
            r_busy_cnt <= BUSY_W'(WR_BUSY_CYCLES - 1);
          end else if (r_wren_pend && !r_wip) begin
            r_wel <= 1'b1;
          end else if (r_wrdi_pend) begin
            r_wel <= 1'b0;
          end
        end
        r_state     <= ST_IDLE;
        r_bit_cnt   <= '0;
        r_tx_cnt    <= '0;
        r_miso      <= 1'b0;
        r_miso_oe   <= 1'b0;
        r_wren_pend <= 1'b0;
        r_wrdi_pend <= 1'b0;
        r_wr_any    <= 1'b0;
      end else begin
        if (r_state == ST_IDLE) r_state <= ST_CMD;

        if (w_sck_rise) begin
          case (r_state)
            ST_CMD: begin
              r_shift_in <= w_byte[6:0];
              r_bit_cnt  <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == CNT_W'(7)) begin
                r_bit_cnt <= '0;
                r_tx_cnt  <= '0;
                r_is_read <= (w_byte == CMD_READ);
                if (r_wip && (w_byte != CMD_RDSR)) begin
                  r_state <= ST_IGNORE;
                end else begin
                  case (w_byte)
                    CMD_READ:  r_state <= ST_ADDR;
                    CMD_WRITE: r_state <= (r_wel && bus.SPI_WP_N) ? ST_ADDR : ST_IGNORE;
                    CMD_WREN:  begin r_wren_pend <= 1'b1; r_state <= ST_IGNORE; end
                    CMD_WRDI:  begin r_wrdi_pend <= 1'b1; r_state <= ST_IGNORE; end
                    CMD_RDSR:  r_state <= ST_STATUS;
                    default:   r_state <= ST_IGNORE;
                  endcase
                end
              end
            end
            ST_ADDR: begin
              r_addr    <= {r_addr[ADDR_W-2:0], w_mosi};
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == CNT_W'(ADDR_W - 1)) begin
                r_bit_cnt <= '0;
                if (r_is_read) begin
                  r_state   <= ST_RD_DATA;
                  r_rd_pend <= 1'b1;
                end else begin
                  r_state <= ST_WR_DATA;
                end
              end
            end
            ST_RD_DATA: begin
              // Prefetch the next byte so it is registered before the next fall.
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == CNT_W'(7)) begin
                r_bit_cnt <= '0;
                r_rd_pend <= 1'b1;
              end
            end
            ST_WR_DATA: begin
              r_shift_in <= w_byte[6:0];
              r_bit_cnt  <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == CNT_W'(7)) begin
                r_bit_cnt <= '0;
                r_wr_pend <= 1'b1;
                r_wr_data <= w_byte;
                r_wr_any  <= 1'b1;
              end
            end
            default: ;
          endcase
        end

        if (w_sck_fall && ((r_state == ST_RD_DATA) || (r_state == ST_STATUS))) begin
          r_miso_oe <= 1'b1;
          r_tx_cnt  <= r_tx_cnt + 1'b1;
          if (r_tx_cnt == '0) begin
            r_miso     <= w_tx_byte[7];
            r_tx_shift <= {w_tx_byte[6:0], 1'b0};
          end else begin
            r_miso     <= r_tx_shift[7];
            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
          end
        end
      end
    end
  end

  // NOTE: the RAM array and its read register carry no reset; stored bytes
  // must survive RST_N_I and a reset port would block RAM inference.
  logic [7:0] r_mem [DEPTH] = '{default: 8'hFF};

  always_ff @(posedge CLK_I) begin
    if (r_wr_pend) r_mem[r_addr] <= r_wr_data;
    if (r_rd_pend) r_rd_data     <= r_mem[r_addr];
  end

  assign bus.SPI_MISO    = r_miso;
  assign bus.SPI_MISO_OE = r_miso_oe;
  assign bus.BUSY_O      = r_wip;

endmodule

// File: tb/tb_spi_mem_responder.sv
// Directed bench for spi_mem_responder. A mode-0 master drives the pins at
// 10 CLK_I cycles per SCK period; a monitor assembles MISO bytes on SCK rise
// while MISO_OE is high and compares them against a queue of expected bytes.
module tb_spi_mem_responder;

  // Each SPI byte spans 80 CLK_I cycles at this rate, so the busy window is
  // widened to let an RDSR and a WREN transaction land inside it.
  localparam int BUSY = 400;

  logic clk;
  logic rst_n;
  spi_mem_if u_if ();

  spi_mem_responder #(
    .ADDR_W         (8),
    .PAGE_BYTES     (16),
    .WR_BUSY_CYCLES (BUSY)
  ) u_dut (
    .CLK_I   (clk),
    .RST_N_I (rst_n),
    .bus     (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: master samples MISO on SCK rise.
  int         mon_bits = 0;
  logic [7:0] mon_byte = '0;
  logic [7:0] mon_exp;
  always @(posedge u_if.SPI_CLK or posedge u_if.SPI_CS_N) begin
    if (u_if.SPI_CS_N) begin
      mon_bits = 0;
    end else if (u_if.SPI_MISO_OE) begin
      mon_byte = {mon_byte[6:0], u_if.SPI_MISO};
      mon_bits++;
      if (mon_bits == 8) begin
        mon_bits = 0;
        check("sb_byte_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check("sb_miso_byte", {24'd0, mon_byte}, {24'd0, mon_exp});
        end
      end
    end
  end

  // Cycle counters sampled on the inactive clock edge.
  int oe_cycles = 0;
  int busy_run  = 0;
  int busy_len  = 0;
  always @(negedge clk) begin
    if (u_if.SPI_MISO_OE) oe_cycles++;
    if (u_if.BUSY_O) busy_run++;
    else if (busy_run != 0) begin
      busy_len = busy_run;
      busy_run = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    tick(1);
    u_if.SPI_CS_N = 1'b0;
    tick(5);
  endtask

  task automatic cs_high();
    tick(5);
    u_if.SPI_CS_N = 1'b1;
    tick(10);
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int nb);
    for (int i = 0; i < nb; i++) begin
      u_if.SPI_MOSI = tx[7-i];
      tick(5);
      u_if.SPI_CLK = 1'b1;
      tick(5);
      u_if.SPI_CLK = 1'b0;
    end
  endtask

  task automatic simple_cmd(input logic [7:0] op);
    cs_low();
    xfer_bits(op, 8);
    cs_high();
  endtask

  task automatic do_read(input logic [7:0] addr, input int n);
    cs_low();
    xfer_bits(8'h03, 8);
    xfer_bits(addr, 8);
    for (int i = 0; i < n; i++) xfer_bits(8'h00, 8);
    cs_high();
  endtask

  task automatic do_rdsr(input int n);
    cs_low();
    xfer_bits(8'h05, 8);
    for (int i = 0; i < n; i++) xfer_bits(8'h00, 8);
    cs_high();
  endtask

  // Sends n data bytes taken MSB-first from data.
  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input int n);
    cs_low();
    xfer_bits(8'h02, 8);
    xfer_bits(addr, 8);
    for (int i = 0; i < n; i++) xfer_bits(data[31-8*i -: 8], 8);
    cs_high();
  endtask

  task automatic wait_not_busy();
    for (int i = 0; i < 2000 && u_if.BUSY_O; i++) tick(1);
    check("busy_clears", {31'd0, u_if.BUSY_O}, 32'd0);
    tick(2);
  endtask

  int oe_snap;

  initial begin
    rst_n         = 1'b0;
    u_if.SPI_CLK  = 1'b0;
    u_if.SPI_CS_N = 1'b1;
    u_if.SPI_MOSI = 1'b0;
    u_if.SPI_WP_N = 1'b1;
    tick(2);
    check("rst_miso", {31'd0, u_if.SPI_MISO}, 32'd0);
    check("rst_oe",   {31'd0, u_if.SPI_MISO_OE}, 32'd0);
    check("rst_busy", {31'd0, u_if.BUSY_O}, 32'd0);
    rst_n = 1'b1;
    tick(5);

    // Erased memory reads 0xFF and the address wraps 0xFF -> 0x00.
    repeat (4) exp_q.push_back(8'hFF);
    do_read(8'hFE, 4);
    exp_q.push_back(8'h00);
    do_rdsr(1);

    // WREN sets WEL; status is refreshed for every byte.
    simple_cmd(8'h06);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h02);
    do_rdsr(2);

    // Two-byte write; WIP=1 / WEL=0 right after; WREN during WIP is ignored.
    do_write(8'h10, 32'hA55A_0000, 2);
    exp_q.push_back(8'h01);
    do_rdsr(1);
    simple_cmd(8'h06);
    wait_not_busy();
    check("busy_len", busy_len, BUSY);
    exp_q.push_back(8'h00);
    do_rdsr(1);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    do_read(8'h10, 2);

    // Write crossing the page end wraps to the page start.
    simple_cmd(8'h06);
    do_write(8'h1E, 32'h0102_0304, 4);
    wait_not_busy();
    check("busy_len_2", busy_len, BUSY);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    do_read(8'h1E, 2);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'hFF);
    do_read(8'h10, 3);

    // WRITE without WEL is dropped.
    oe_snap = oe_cycles;
    do_write(8'h40, 32'h7700_0000, 1);
    check("nowel_oe_cycles", oe_cycles - oe_snap, 0);
    check("nowel_busy", {31'd0, u_if.BUSY_O}, 32'd0);
    exp_q.push_back(8'hFF);
    do_read(8'h40, 1);
    exp_q.push_back(8'h00);
    do_rdsr(1);

    // WRITE with write-protect asserted is dropped and WEL is kept.
    simple_cmd(8'h06);
    u_if.SPI_WP_N = 1'b0;
    oe_snap = oe_cycles;
    do_write(8'h40, 32'h7700_0000, 1);
    check("wp_oe_cycles", oe_cycles - oe_snap, 0);
    check("wp_busy", {31'd0, u_if.BUSY_O}, 32'd0);
    u_if.SPI_WP_N = 1'b1;
    exp_q.push_back(8'hFF);
    do_read(8'h40, 1);
    exp_q.push_back(8'h02);
    do_rdsr(1);
    simple_cmd(8'h04);
    exp_q.push_back(8'h00);
    do_rdsr(1);

    // Partial data byte (5 bits) is discarded and WEL is kept.
    simple_cmd(8'h06);
    cs_low();
    xfer_bits(8'h02, 8);
    xfer_bits(8'h50, 8);
    xfer_bits(8'h22, 5);
    cs_high();
    check("partial_busy", {31'd0, u_if.BUSY_O}, 32'd0);
    exp_q.push_back(8'h02);
    do_rdsr(1);
    exp_q.push_back(8'hFF);
    do_read(8'h50, 1);
    simple_cmd(8'h04);

    // Reset pulse in the middle of a read data byte.
    cs_low();
    xfer_bits(8'h03, 8);
    xfer_bits(8'h1E, 8);
    xfer_bits(8'h00, 3);
    tick(1);
    rst_n = 1'b0;
    #1;
    check("midrst_miso", {31'd0, u_if.SPI_MISO}, 32'd0);
    check("midrst_oe",   {31'd0, u_if.SPI_MISO_OE}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    cs_high();
    exp_q.push_back(8'h00);
    do_rdsr(1);
    exp_q.push_back(8'h01);
    do_read(8'h1E, 1);

    tick(5);
    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
